// File: rtl/pipe_skid_reg.sv
// Two-slot pipeline register (main + skid) with exception merge, flush-to-handler and saturating stall counter.
// Latency: 1 cycle. Backpressure: in_ready registered from state, low only when both slots are full.
module pipe_skid_reg #(
    parameter int                DATA_W     = 32,
    parameter int                PC_W       = 32,
    parameter int                EXC_W      = 5,
    parameter logic [PC_W-1:0]   HANDLER_PC = 'h0000_4180,
    parameter int                CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [EXC_W-1:0]   in_exc,
    input  logic               in_bd,
    input  logic [EXC_W-1:0]   local_exc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [PC_W-1:0]    out_pc,
    output logic [EXC_W-1:0]   out_exc,
    output logic               out_bd,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q;
    logic [DATA_W-1:0]   main_data, skid_data;
    logic [PC_W-1:0]     main_pc, skid_pc;
    logic [EXC_W-1:0]    main_exc, skid_exc;
    logic                main_bd, skid_bd;
    logic [CNT_W-1:0]    stall_q;

    logic                in_fire, out_fire;
    logic                load_main_in, load_main_skid, load_skid;
    logic [EXC_W-1:0]    cap_exc;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = main_data;
    assign out_pc    = main_pc;
    assign out_exc   = main_exc;
    assign out_bd    = main_bd;
    assign stall_cnt = stall_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;
    // Upstream stage's exception is older, so it takes precedence over ours.
    assign cap_exc  = (in_exc != '0) ? in_exc : local_exc;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_d      = S_ONE;
                end
            end
            S_ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = S_FULL;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_d        = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
            main_data  <= '0;
            main_pc    <= '0;
            main_exc   <= '0;
            main_bd    <= 1'b0;
            skid_data  <= '0;
            skid_pc    <= '0;
            skid_exc   <= '0;
            skid_bd    <= 1'b0;
            stall_q    <= '0;
        end else if (flush) begin
            // Discard both slots and any coincident capture; main presents the handler PC.
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
            main_data  <= '0;
            main_pc    <= HANDLER_PC;
            main_exc   <= '0;
            main_bd    <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_FULL);
            if (load_main_in) begin
                main_data <= in_data;
                main_pc   <= in_pc;
                main_exc  <= cap_exc;
                main_bd   <= in_bd;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_pc   <= skid_pc;
                main_exc  <= skid_exc;
                main_bd   <= skid_bd;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_pc   <= in_pc;
                skid_exc  <= cap_exc;
                skid_bd   <= in_bd;
            end
            if (out_valid && !out_ready && !(&stall_q)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: inputs driven and outputs checked on the falling edge.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [31:0] in_data;
    logic [31:0] in_pc;
    logic [4:0]  in_exc;
    logic        in_bd;
    logic [4:0]  local_exc;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [31:0] out_data, out_data2;
    logic [31:0] out_pc, out_pc2;
    logic [4:0]  out_exc, out_exc2;
    logic        out_bd, out_bd2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_pc(in_pc), .in_exc(in_exc), .in_bd(in_bd),
        .local_exc(local_exc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_pc(out_pc), .out_exc(out_exc), .out_bd(out_bd),
        .stall_cnt(stall_cnt)
    );

    pipe_skid_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_pc(in_pc), .in_exc(in_exc), .in_bd(in_bd),
        .local_exc(local_exc),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_pc(out_pc2), .out_exc(out_exc2), .out_bd(out_bd2),
        .stall_cnt(stall_cnt2)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_pc = '0; in_exc = '0; in_bd = 1'b0; local_exc = '0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        in_data = 32'hdead_beef; in_pc = 32'h1234; in_exc = 5'd3; in_bd = 1'b1; local_exc = 5'd7;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        checks++;
        if (out_data !== 32'h0 || out_pc !== 32'h0 || out_exc !== 5'h0 || out_bd !== 1'b0 || stall_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_payload: data=%h pc=%h exc=%h bd=%b cnt=%0d required all 0",
                     out_data, out_pc, out_exc, out_bd, stall_cnt);
        end
        flush = 1'b0; in_valid = 1'b0; reset = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pc = pcs[i]; in_data = 32'hA000 + i; in_bd = i[0];
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_data !== 32'hA000 + i ||
                out_bd !== i[0] || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: v=%b pc=%h data=%h bd=%b rdy=%b required 1 %h %h %b 1",
                         i, out_valid, out_pc, out_data, out_bd, in_ready, pcs[i], 32'hA000 + i, i[0]);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h3000; in_data = 32'h11;
        step();
        in_pc = 32'h3004; in_data = 32'h22;
        step();
        checks++;
        if (in_ready !== 1'b0 || out_pc !== 32'h3000 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: rdy=%b pc=%h v=%b required 0 3000 1", in_ready, out_pc, out_valid);
        end
        in_pc = 32'h3008; in_data = 32'h33;
        step();
        checks++;
        if (in_ready !== 1'b0 || out_pc !== 32'h3000) begin
            errors++;
            $display("FAIL bp_hold: rdy=%b pc=%h required 0 3000", in_ready, out_pc);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_pc !== 32'h3004 || out_data !== 32'h22 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: pc=%h data=%h rdy=%b required 3004 22 1", out_pc, out_data, in_ready);
        end
        step();
        checks++;
        if (out_pc !== 32'h3008 || out_data !== 32'h33 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_third: pc=%h data=%h v=%b required 3008 33 1", out_pc, out_data, out_valid);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_exc_merge();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'h5000; in_data = 32'h55; in_bd = 1'b1;
        in_exc = 5'd4; local_exc = 5'd10;
        step();
        checks++;
        if (out_exc !== 5'd4 || out_pc !== 32'h5000 || out_data !== 32'h55 || out_bd !== 1'b1) begin
            errors++;
            $display("FAIL exc_upstream: exc=%0d pc=%h data=%h bd=%b required 4 5000 55 1",
                     out_exc, out_pc, out_data, out_bd);
        end
        in_exc = 5'd0; in_pc = 32'h5004; in_bd = 1'b0;
        step();
        checks++;
        if (out_exc !== 5'd10 || out_pc !== 32'h5004 || out_bd !== 1'b0) begin
            errors++;
            $display("FAIL exc_local: exc=%0d pc=%h bd=%b required 10 5004 0", out_exc, out_pc, out_bd);
        end
        // Exception held in the skid slot must survive the move into main.
        out_ready = 1'b0; in_exc = 5'd0; local_exc = 5'd12; in_pc = 32'h5008;
        step();
        in_valid = 1'b0; out_ready = 1'b1; local_exc = 5'd0;
        step();
        checks++;
        if (out_exc !== 5'd12 || out_pc !== 32'h5008) begin
            errors++;
            $display("FAIL exc_skid: exc=%0d pc=%h required 12 5008", out_exc, out_pc);
        end
        in_exc = '0;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h6000; in_data = 32'h60;
        step();
        in_pc = 32'h6004; in_data = 32'h64;
        step();
        in_pc = 32'h6008; in_data = 32'h68; flush = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h4180 || out_data !== 32'h0 ||
            out_exc !== 5'h0 || out_bd !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: v=%b pc=%h data=%h exc=%h bd=%b rdy=%b required 0 4180 0 0 0 1",
                     out_valid, out_pc, out_data, out_exc, out_bd, in_ready);
        end
        // Flush in ONE with a real in_fire: new entry must be dropped too.
        flush = 1'b0; out_ready = 1'b1; in_pc = 32'h6100;
        step();
        flush = 1'b1; in_pc = 32'h6104;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h4180) begin
            errors++;
            $display("FAIL flush_one: v=%b pc=%h required 0 4180", out_valid, out_pc);
        end
        flush = 1'b0; in_pc = 32'h7000; in_data = 32'h70;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h7000 || out_data !== 32'h70) begin
            errors++;
            $display("FAIL flush_after: v=%b pc=%h data=%h required 1 7000 70", out_valid, out_pc, out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_stale: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_stall_cnt();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h8000;
        step();
        in_valid = 1'b0;
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stall_start: cnt=%0d required 0", stall_cnt);
        end
        repeat (5) step();
        checks++;
        if (stall_cnt !== 16'd5 || stall_cnt2 !== 2'd3) begin
            errors++;
            $display("FAIL stall_five: cnt=%0d sat=%0d required 5 3", stall_cnt, stall_cnt2);
        end
        step();
        checks++;
        if (stall_cnt !== 16'd6 || stall_cnt2 !== 2'd3) begin
            errors++;
            $display("FAIL stall_six: cnt=%0d sat=%0d required 6 3", stall_cnt, stall_cnt2);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        checks++;
        if (stall_cnt !== 16'd6) begin
            errors++;
            $display("FAIL stall_flush: cnt=%0d required 6", stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h9000; in_data = 32'h90; in_bd = 1'b1; in_exc = 5'd2;
        step();
        in_pc = 32'h9004;
        step();
        step();
        reset = 1'b0; flush = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_data !== 32'h0 || out_exc !== 5'h0 ||
            out_bd !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid: v=%b pc=%h data=%h exc=%h bd=%b rdy=%b cnt=%0d required 0 0 0 0 0 1 0",
                     out_valid, out_pc, out_data, out_exc, out_bd, in_ready, stall_cnt);
        end
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_exc = '0; in_bd = 1'b0;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_pc = '0; in_exc = '0; in_bd = 1'b0; local_exc = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_exc_merge();
        test_flush();
        test_stall_cnt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning instruction/payload width.
REQ-002 The block SHALL have parameter PC_W, default 32, meaning PC width.
REQ-003 The block SHALL have parameter EXC_W, default 5, meaning exception-code width; code 0 = no exception.
REQ-004 The block SHALL have parameter HANDLER_PC, default 32'h0000_4180, meaning the PC loaded on flush.
REQ-005 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset (asserted when 0).
REQ-008 The block SHALL have port flush, input, 1: exception/eret request from the pipeline control.
REQ-009 The block SHALL have port in_valid, input, 1: upstream entry present.
REQ-010 The block SHALL have port in_ready, output, 1: block accepts an entry this cycle.
REQ-011 The block SHALL have ports in_data (DATA_W), in_pc (PC_W), in_exc (EXC_W) and in_bd (1), all inputs: the upstream payload.
REQ-012 The block SHALL have port local_exc, input, EXC_W: exception detected at this stage boundary; 0 = none.
REQ-013 The block SHALL have port out_valid, output, 1: downstream entry present.
REQ-014 The block SHALL have port out_ready, input, 1: downstream accepts.
REQ-015 The block SHALL have ports out_data, out_pc, out_exc and out_bd, all outputs with widths matching their inputs: the registered payload.
REQ-016 The block SHALL have port stall_cnt, output, CNT_W: count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Two entry slots SHALL exist: main (drives out_*) and skid. State SHALL be one of EMPTY (neither valid), ONE (main valid), FULL (both valid).
REQ-018 in_ready SHALL be 1 iff state != FULL; it SHALL be a registered function of state, with no combinational path from out_ready.
REQ-019 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; out_valid SHALL equal 1 iff state != EMPTY.
REQ-020 EMPTY: in_fire loads main and goes to ONE.
REQ-021 ONE: in_fire & out_fire loads main with the new entry and stays ONE. in_fire alone loads skid and goes to FULL. out_fire alone goes to EMPTY.
REQ-022 FULL: out_fire moves skid into main and goes to ONE; otherwise no change.
REQ-023 Latency SHALL be 1 cycle: an entry accepted in cycle N appears on out_* in cycle N+1 when main is free.
REQ-024 Exception merge on capture: stored exc = in_exc if in_exc != 0, else local_exc; the earlier stage's code SHALL win.
REQ-025 in_data, in_pc and in_bd SHALL be stored unchanged regardless of the exception code.
REQ-026 Flush SHALL override all handshakes in the same cycle. Next state SHALL be EMPTY, with the skid slot invalidated.
REQ-027 On flush, main payload SHALL load out_data=0, out_pc=HANDLER_PC, out_exc=0 and out_bd=0.
REQ-028 Any in_fire coincident with flush SHALL be dropped; in_ready SHALL still read its registered value that cycle.
REQ-029 stall_cnt SHALL increment on each cycle with out_valid & ~out_ready & ~flush. It SHALL saturate at all-ones and SHALL NOT wrap.
REQ-030 Ordering SHALL be strict FIFO: an entry SHALL never overtake, duplicate or be lost, except entries discarded by flush.

Reset
REQ-031 While reset=0 at a rising edge, state SHALL become EMPTY and in_ready SHALL be 1.
REQ-032 On that same reset edge, out_data, out_pc, out_exc, out_bd and stall_cnt SHALL all become 0.
REQ-033 Reset SHALL take priority over flush and over all handshakes, including mid-FULL.
REQ-034 Outputs SHALL be valid from the first edge after reset=1.

Verification
REQ-035 Stream: out_ready=1; feed pc 0x3000, 0x3004, 0x3008 back-to-back -> out_pc = 0x3000, 0x3004, 0x3008 on cycles N+1..N+3; in_ready stays 1.
REQ-036 Backpressure: out_ready=0 after 0x3000 is accepted; offer 0x3004 -> state FULL and in_ready=0. 0x3008 is held upstream. Raise out_ready -> outputs 0x3000, 0x3004, 0x3008 in order.
REQ-037 Exception merge: in_exc=4, local_exc=10 -> out_exc=4. in_exc=0, local_exc=10 -> out_exc=10.
REQ-038 Flush while FULL with in_fire asserted -> next cycle out_valid=0, out_pc=0x4180, out_data=0, in_ready=1; both buffered entries and the incoming entry are gone.
REQ-039 Stall count: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5. With CNT_W=2, after 6 cycles -> stall_cnt=3 (saturated).
REQ-040 Reset mid-operation: reset=0 while FULL with flush=1 -> all outputs 0, out_pc=0 (not HANDLER_PC), in_ready=1.
